// File: rtl/dmem_sized_sync.sv
// dmem_sized_sync: byte-addressed RV32 data memory with sized accesses.
//
// Loads and stores may be byte, half or word sized. Loads are sign- or
// zero-extended. Reads are registered, so each accepted request produces
// exactly one response one cycle later. After reset the array is cleared
// one word per cycle, and no requests are accepted until the clear is done.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only when the array is idle and
// cleared. The response (rsp_valid pulse with rsp_rdata/rsp_err) follows the
// transfer edge by one cycle and cannot be stalled.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_size          RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   rsp_valid         one-cycle response pulse
//   rsp_rdata         extended load data; 0 for stores and errors
//   rsp_err           access error, qualified by rsp_valid
//   busy              high while the post-reset clear runs
//
// Build option: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word
// accesses as errors; otherwise they are silently aligned down.
module dmem_sized_sync #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] clr_cnt;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_hi;
  logic              in_range;
  logic              size_ok;
  logic              misalign;
  logic              acc_err;
  logic [1:0]        lane_eff;
  logic [3:0]        be;
  logic [31:0]       wd_lanes;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_data;
  logic              accept;
  logic              do_write;

  assign idx      = req_addr[IDX_W+1:2];
  assign lane     = req_addr[1:0];
  // Any set bit above the array's byte range means out of range.
  assign addr_hi  = req_addr >> (IDX_W + 2);
  assign in_range = (addr_hi == '0);

  assign req_ready = (state == ST_READY);
  assign busy      = (state == ST_CLEAR);
  assign accept    = req_valid && (state == ST_READY);
  assign do_write  = accept && req_we && !acc_err;

  always_comb begin
    size_ok = 1'b0;
    case (req_size)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = !req_we;  // unsigned forms are load-only
      default:                size_ok = 1'b0;
    endcase

    // Effective lane is the aligned-down lane; misalign records whether
    // alignment had to discard any address bits.
    lane_eff = lane;
    misalign = 1'b0;
    case (req_size[1:0])
      2'b01: begin
        misalign = lane[0];
        lane_eff = {lane[1], 1'b0};
      end
      2'b10: begin
        misalign = (lane != 2'b00);
        lane_eff = 2'b00;
      end
      default: ;
    endcase

`ifdef DMEM_MISALIGN_CHECK_EN
    acc_err = !in_range || !size_ok || misalign;
`else
    acc_err = !in_range || !size_ok;
`endif

    case (req_size[1:0])
      2'b00:   be = 4'b0001 << lane_eff;
      2'b01:   be = 4'b0011 << lane_eff;
      default: be = 4'b1111;
    endcase

    // Replicate store data so each enabled lane sees its own byte.
    case (req_size[1:0])
      2'b00:   wd_lanes = {4{req_wdata[7:0]}};
      2'b01:   wd_lanes = {2{req_wdata[15:0]}};
      default: wd_lanes = req_wdata;
    endcase

    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane_eff, 3'b000};
    case (req_size)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'd0, rd_shift[7:0]};
      3'b101:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  // Array write port: the clear sweep and accepted stores never overlap
  // because stores are only accepted once the clear has finished.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (!reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) state <= ST_READY;
      end
      rsp_valid <= accept;
      rsp_err   <= accept && acc_err;
      rsp_rdata <= (accept && !acc_err && !req_we) ? ld_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_sized_sync.sv
// Testbench for dmem_sized_sync (DEPTH_WORDS=64). A negedge monitor keeps a
// byte-array reference model, predicts busy/req_ready and every response,
// and compares. Directed sequences also check fixed expected values.
module tb_dmem_sized_sync;

  localparam int DEPTH = 64;
  localparam int BYTES = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_sized_sync #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [7:0]  mem_b [BYTES];
  logic        known = 1'b0;
  int          clr_left = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  logic [31:0] m_a;
  logic [31:0] m_v;
  logic        m_e;
  int          m_n;

  // Inputs change 1 time unit after posedge, so they are stable here.
  always @(negedge clk) begin
    if (known) begin
      check("busy", {31'd0, busy}, {31'd0, clr_left > 0});
      check("req_ready", {31'd0, req_ready}, {31'd0, clr_left == 0});
      if (exp_q.size() > 0) begin
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err_q.pop_front()});
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end else begin
        check("rsp_idle", {31'd0, rsp_valid}, 32'd0);
      end
    end

    // Predict what the coming rising edge does.
    if (reset) begin
      known    = 1'b1;
      clr_left = DEPTH;
      for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h00;
    end else if (known) begin
      if (clr_left > 0) begin
        clr_left--;
      end else if (req_valid) begin
        m_a = req_addr;
        m_e = (m_a >= BYTES) || !(req_size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
              || (req_we && req_size[2]);
        m_n = 1 << req_size[1:0];
`ifdef DMEM_MISALIGN_CHECK_EN
        if (m_a % m_n != 0) m_e = 1'b1;
`else
        m_a = m_a - (m_a % m_n);
`endif
        m_v = 32'd0;
        if (!m_e) begin
          if (req_we) begin
            for (int i = 0; i < m_n; i++) mem_b[m_a + i] = req_wdata[8*i +: 8];
          end else begin
            for (int i = 0; i < m_n; i++) m_v = m_v | (32'(mem_b[m_a + i]) << (8*i));
            if (!req_size[2] && m_n < 4 && m_v[8*m_n-1])
              m_v = m_v | ~((32'd1 << (8*m_n)) - 32'd1);
          end
        end
        exp_q.push_back(m_v);
        exp_err_q.push_back(m_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Single transaction plus a check against a fixed expected result.
  task automatic txn(input string tag, input logic we, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er);
    send(we, sz, a, wd);
    @(negedge clk);
    #1;
    check({tag, "_rdata"}, last_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, last_err}, {31'd0, exp_er});
    tick();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // Counts cycles until req_ready, bounded.
  task automatic wait_ready(input string tag, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (!req_ready && cnt < 200) begin
      tick();
      cnt++;
    end
    check(tag, cnt, exp_cycles);
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  logic [2:0] size_tbl [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    last_rdata = 32'd0;
    last_err   = 1'b0;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    wait_ready("clear_cycles", DEPTH);

    txn("lw0", 0, F_W, 32'h00, 0, 32'h0, 0);
    txn("lw7c", 0, F_W, 32'h7C, 0, 32'h0, 0);
    txn("lwfc", 0, F_W, 32'hFC, 0, 32'h0, 0);

    txn("sw10", 1, F_W, 32'h10, 32'h11223344, 32'h0, 0);
    txn("sb12", 1, F_B, 32'h12, 32'h000000AB, 32'h0, 0);
    txn("lw10", 0, F_W, 32'h10, 0, 32'h11AB3344, 0);
    txn("lbu12", 0, F_BU, 32'h12, 0, 32'h000000AB, 0);
    txn("lb12", 0, F_B, 32'h12, 0, 32'hFFFFFFAB, 0);

    txn("sh22", 1, F_H, 32'h22, 32'h00008001, 32'h0, 0);
    txn("lh22", 0, F_H, 32'h22, 0, 32'hFFFF8001, 0);
    txn("lhu22", 0, F_HU, 32'h22, 0, 32'h00008001, 0);
    txn("lw20", 0, F_W, 32'h20, 0, 32'h80010000, 0);

    // Back-to-back store then load; the monitor checks both response cycles.
    send(1, F_W, 32'h40, 32'hDEADBEEF);
    send(0, F_W, 32'h40, 0);
    @(negedge clk);
    #1;
    check("b2b_rdata", last_rdata, 32'hDEADBEEF);
    tick();

    txn("lw_oor", 0, F_W, 32'h100, 0, 32'h0, 1);
    txn("f3_011", 0, 3'b011, 32'h40, 0, 32'h0, 1);
    txn("sbu_inv", 1, F_BU, 32'h40, 32'h55, 32'h0, 1);
`ifdef DMEM_MISALIGN_CHECK_EN
    txn("lw42", 0, F_W, 32'h42, 0, 32'h0, 1);
    txn("sw42", 1, F_W, 32'h42, 32'h12345678, 32'h0, 1);
    txn("lw40_kept", 0, F_W, 32'h40, 0, 32'hDEADBEEF, 0);
`else
    txn("lw42", 0, F_W, 32'h42, 0, 32'hDEADBEEF, 0);
    txn("lh43", 0, F_HU, 32'h43, 0, 32'h0000DEAD, 0);
`endif

    // Reset at clear counter 30 restarts the full clear.
    do_reset(1);
    repeat (30) tick();
    do_reset(1);
    wait_ready("clear_restart", DEPTH);
    txn("lw10_cleared", 0, F_W, 32'h10, 0, 32'h0, 0);

    // Load presented together with reset: no response next cycle.
    reset = 1'b1;
    send(0, F_W, 32'h10, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_drop", {31'd0, rsp_valid}, 32'd0);
    tick();
    wait_ready("clear_after_drop", DEPTH - 1);

    // Randomized traffic against the model, with idle gaps.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        send(1'($urandom_range(0, 1)), size_tbl[$urandom_range(0, 7)],
             ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 511))
                                          : 32'($urandom_range(0, 255)),
             $urandom);
      end
    end
    // A single reset in the middle of traffic, then more traffic.
    do_reset(1);
    wait_ready("clear_final", DEPTH);
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), size_tbl[$urandom_range(0, 7)],
           32'($urandom_range(0, 255)), $urandom);
    end
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
